// File: rtl/fifo_ram_dma.sv
// FIFO-to-RAM DMA mover: streams `length` words from a read-latency-1 FIFO into RAM at base_addr+n (wrapping).
// Optional macro FIFO_RAM_DMA_TIMEOUT_EN adds an 8-bit stall watchdog that sets the sticky err flag.
//
// Handshake: fifo_rreq is a combinational read strobe; fifo_rdata is valid exactly one
// cycle later, and that cycle is the RAM write cycle (ram_wreq=1, one word per clock).
module fifo_ram_dma #(
  parameter int P_WIDTH_ADDR = 8,
  parameter int P_WIDTH_DATA = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [P_WIDTH_ADDR-1:0] base_addr,
  input  logic [P_WIDTH_ADDR:0]   length,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [P_WIDTH_ADDR:0]   words_done,
  output logic                    fifo_rreq,
  input  logic [P_WIDTH_DATA-1:0] fifo_rdata,
  input  logic                    fifo_rempty,
  output logic                    ram_wreq,
  output logic [P_WIDTH_ADDR-1:0] ram_waddr,
  output logic [P_WIDTH_DATA-1:0] ram_wdata,
  output logic [1:0]              o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [P_WIDTH_ADDR:0] LP_ONE = {{P_WIDTH_ADDR{1'b0}}, 1'b1};

  state_t                  r_state;
  logic [P_WIDTH_ADDR-1:0] r_base;
  logic [P_WIDTH_ADDR:0]   r_len;
  logic [P_WIDTH_ADDR:0]   r_issued;
  logic [P_WIDTH_ADDR:0]   r_words_done;
  logic                    r_rd_valid;

  logic w_rreq;
  logic w_wr;
  logic w_last_wr;
  logic w_timeout;
  logic w_accept;

  assign w_accept  = (r_state == S_IDLE) && start;
  // rst also gates the strobes so a reset abandons an in-flight write in its own cycle.
  assign w_rreq    = (r_state == S_RUN) && !fifo_rempty && (r_issued < r_len) && !abort && !rst;
  assign w_wr      = r_rd_valid && !rst;
  assign w_last_wr = r_rd_valid && ((r_words_done + LP_ONE) == r_len);

`ifdef FIFO_RAM_DMA_TIMEOUT_EN
  logic [7:0] r_stall_cnt;
  logic       r_err;
  logic       w_stall;

  assign w_stall   = (r_state == S_RUN) && fifo_rempty && !r_rd_valid;
  assign w_timeout = w_stall && (r_stall_cnt == 8'd254);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 8'd0;
      r_err       <= 1'b0;
    end else begin
      r_stall_cnt <= w_stall ? r_stall_cnt + 8'd1 : 8'd0;
      if (w_accept) begin
        r_err <= 1'b0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_base       <= '0;
      r_len        <= '0;
      r_issued     <= '0;
      r_words_done <= '0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_rd_valid <= w_rreq;
      if (w_rreq) begin
        r_issued <= r_issued + LP_ONE;
      end
      if (r_rd_valid) begin
        r_words_done <= r_words_done + LP_ONE;
      end
      case (r_state)
        S_IDLE: begin
          // A zero-length start still counts as an accepted transfer of zero words.
          if (start) begin
            r_base       <= base_addr;
            r_len        <= length;
            r_issued     <= '0;
            r_words_done <= '0;
            r_state      <= (length == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (abort || w_last_wr || w_timeout) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign words_done  = r_words_done;
  assign fifo_rreq   = w_rreq;
  assign ram_wreq    = w_wr;
  assign ram_waddr   = w_wr ? (r_base + r_words_done[P_WIDTH_ADDR-1:0]) : '0;
  assign ram_wdata   = w_wr ? fifo_rdata : '0;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fifo_ram_dma.sv
// Bench for fifo_ram_dma: behavioural FIFO, expected-write scoreboard, directed and random transfers.
module tb_fifo_ram_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [8:0]  length = '0;
  logic        busy, done, err, fifo_rreq, ram_wreq;
  logic [8:0]  words_done;
  logic [15:0] fifo_rdata = '0;
  logic        fifo_rempty = 1'b1;
  logic [7:0]  ram_waddr;
  logic [15:0] ram_wdata;
  logic [1:0]  dbg_state;

  logic        push_en = 1'b0;
  logic [15:0] push_data = '0;
  logic        flush = 1'b0;
  logic [15:0] fifo_q[$];
  logic [23:0] exp_q[$];

  int n_chk = 0;
  int n_err = 0;
  int rreq_total = 0;
  int wr_total = 0;

  fifo_ram_dma #(.P_WIDTH_ADDR(8), .P_WIDTH_DATA(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .err(err), .words_done(words_done),
    .fifo_rreq(fifo_rreq), .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty),
    .ram_wreq(ram_wreq), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural FIFO: one-cycle read latency, pushes become visible the cycle after.
  always @(posedge clk) begin
    if (flush) begin
      fifo_q.delete();
    end else begin
      if (fifo_rreq) begin
        rreq_total++;
        if (fifo_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL fifo_underflow: read request with empty fifo");
        end else begin
          fifo_rdata <= fifo_q.pop_front();
        end
      end
      if (push_en) fifo_q.push_back(push_data);
    end
    fifo_rempty <= (fifo_q.size() == 0);
  end

  // Monitor: every RAM write must match the head of the expected queue.
  always @(negedge clk) begin
    if (ram_wreq) begin
      wr_total++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL ram_write_unexpected: addr %0h data %0h, none expected", ram_waddr, ram_wdata);
      end else begin
        check("ram_write", {8'h00, ram_waddr, ram_wdata}, {8'h00, exp_q.pop_front()});
      end
    end else if (!rst) begin
      check("ram_bus_idle", {8'h00, ram_waddr, ram_wdata}, 32'h0);
    end
  end

  task automatic push_word(input logic [15:0] v);
    push_en   = 1'b1;
    push_data = v;
    @(negedge clk);
    push_en   = 1'b0;
  endtask

  // Reference model: word i of a transfer lands at (base+i) mod 256 in FIFO order.
  task automatic push_exp(input logic [7:0] b, input int i, input logic [15:0] v);
    logic [7:0] a;
    a = b + 8'(i);
    exp_q.push_back({a, v});
    push_word(v);
  endtask

  task automatic start_xfer(input logic [7:0] b, input logic [8:0] l);
    base_addr = b;
    length    = l;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cnt, output logic [31:0] wmask, output int busy_gaps);
    cnt = 1;
    wmask = '0;
    busy_gaps = 0;
    while (!done && cnt < budget) begin
      if (cnt < 32) wmask[cnt] = ram_wreq;
      if (!busy) busy_gaps++;
      @(negedge clk);
      cnt++;
    end
    if (!done) begin
      n_chk++;
      n_err++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic finish_xfer(input string name, input int exp_words, input logic exp_err);
    check({name, "_words_done"}, 32'(words_done), 32'(exp_words));
    check({name, "_err"}, 32'(err), 32'(exp_err));
    check({name, "_busy_at_done"}, 32'(busy), 32'h0);
    @(negedge clk);
    check({name, "_done_single"}, 32'(done), 32'h0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int cnt, gaps, r0, w0, l, pre;
    logic [31:0] m;
    logic [7:0] b;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_flags", {busy, done, err, fifo_rreq, ram_wreq}, 32'h0);
    check("reset_words_done", 32'(words_done), 32'h0);
    check("reset_state", 32'(dbg_state), 32'h0);

    // Four preloaded words, writes in cycles 2..5, done in cycle 6.
    push_exp(8'h10, 0, 16'h1111);
    push_exp(8'h10, 1, 16'h2222);
    push_exp(8'h10, 2, 16'h3333);
    push_exp(8'h10, 3, 16'h4444);
    @(negedge clk);
    start_xfer(8'h10, 9'd4);
    wait_done(50, cnt, m, gaps);
    check("basic_done_cycle", 32'(cnt), 32'd6);
    check("basic_write_cycles", m, 32'h3C);
    finish_xfer("basic", 4, 1'b0);

    // Address wrap across 0xFF.
    for (int i = 0; i < 4; i++) push_exp(8'hFE, i, 16'(16'hA000 + i));
    start_xfer(8'hFE, 9'd4);
    wait_done(50, cnt, m, gaps);
    finish_xfer("wrap", 4, 1'b0);
    check("wrap_drained", 32'(exp_q.size()), 32'h0);

    // Two words, ten-cycle stall, two more words.
    push_exp(8'h20, 0, 16'hB001);
    push_exp(8'h20, 1, 16'hB002);
    w0 = wr_total;
    start_xfer(8'h20, 9'd4);
    gaps = 0;
    repeat (10) begin
      if (!busy || done) gaps++;
      @(negedge clk);
    end
    check("stall_busy", 32'(gaps), 32'h0);
    check("stall_writes", 32'(wr_total - w0), 32'd2);
    push_exp(8'h20, 2, 16'hB003);
    push_exp(8'h20, 3, 16'hB004);
    wait_done(50, cnt, m, gaps);
    check("stall_busy_gaps", 32'(gaps), 32'h0);
    finish_xfer("stall", 4, 1'b0);

    // Abort on the cycle of the third read request.
    for (int i = 0; i < 8; i++) begin
      if (i < 2) push_exp(8'h30, i, 16'(16'hC000 + i));
      else push_word(16'(16'hC000 + i));
    end
    @(negedge clk);
    r0 = rreq_total;
    start_xfer(8'h30, 9'd8);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    wait_done(20, cnt, m, gaps);
    abort = 1'b0;
    check("abort_done_cycle", 32'(cnt), 32'd2);
    check("abort_rreqs", 32'(rreq_total - r0), 32'd2);
    finish_xfer("abort", 2, 1'b0);
    do_flush();

    // Zero length: done next cycle, no bus activity.
    r0 = rreq_total;
    w0 = wr_total;
    push_word(16'hDEAD);
    start_xfer(8'h55, 9'd0);
    wait_done(10, cnt, m, gaps);
    check("zero_done_cycle", 32'(cnt), 32'd1);
    check("zero_rreqs", 32'(rreq_total - r0), 32'h0);
    check("zero_writes", 32'(wr_total - w0), 32'h0);
    finish_xfer("zero", 0, 1'b0);
    do_flush();

    // Start while busy is ignored.
    start_xfer(8'h40, 9'd4);
    @(negedge clk);
    @(negedge clk);
    start_xfer(8'h80, 9'd2);
    for (int i = 0; i < 4; i++) push_exp(8'h40, i, 16'(16'hE000 + i));
    wait_done(60, cnt, m, gaps);
    finish_xfer("busy_start", 4, 1'b0);

    // Reset mid-run: the write in the reset cycle must not happen.
    for (int i = 0; i < 8; i++) begin
      if (i == 0) push_exp(8'h60, 0, 16'hF000);
      else push_word(16'(16'hF000 + i));
    end
    @(negedge clk);
    start_xfer(8'h60, 9'd8);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_flags", {busy, done, err, fifo_rreq, ram_wreq}, 32'h0);
    check("midrst_bus", {8'h00, ram_waddr, ram_wdata}, 32'h0);
    check("midrst_words_done", 32'(words_done), 32'h0);
    rst = 1'b0;
    do_flush();
    check("midrst_drained", 32'(exp_q.size()), 32'h0);

    // Maximum length 256 streamed at one word per clock.
    start_xfer(8'h9C, 9'd256);
    for (int i = 0; i < 256; i++) push_exp(8'h9C, i, 16'($urandom));
    wait_done(50, cnt, m, gaps);
    finish_xfer("len256", 256, 1'b0);

    // Random transfers with random preload and push gaps.
    for (int t = 0; t < 20; t++) begin
      b   = 8'($urandom_range(0, 255));
      l   = $urandom_range(1, 24);
      pre = $urandom_range(0, l);
      for (int i = 0; i < pre; i++) push_exp(b, i, 16'($urandom));
      start_xfer(b, 9'(l));
      for (int i = pre; i < l; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        push_exp(b, i, 16'($urandom));
      end
      wait_done(100, cnt, m, gaps);
      finish_xfer("random", l, 1'b0);
    end

`ifdef FIFO_RAM_DMA_TIMEOUT_EN
    start_xfer(8'h70, 9'd1);
    wait_done(400, cnt, m, gaps);
    check("timeout_done_cycle", 32'(cnt), 32'd256);
    finish_xfer("timeout", 0, 1'b1);
    @(negedge clk);
    check("timeout_err_sticky", 32'(err), 32'h1);
    start_xfer(8'h71, 9'd0);
    wait_done(10, cnt, m, gaps);
    check("timeout_err_cleared", 32'(err), 32'h0);
`else
    start_xfer(8'h70, 9'd1);
    gaps = 0;
    repeat (300) begin
      if (!busy || done || err) gaps++;
      @(negedge clk);
    end
    check("no_timeout_waits", 32'(gaps), 32'h0);
    push_exp(8'h70, 0, 16'h7777);
    wait_done(20, cnt, m, gaps);
    finish_xfer("no_timeout", 1, 1'b0);
`endif

    repeat (3) @(negedge clk);
    check("final_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1);
  end

endmodule
